// File: rtl/swd_engine_if.sv
// Request, configuration, result and SWD wire signals of the SWD engine.
// The engine attaches to the slave modport; the host controller attaches to the master modport.
interface swd_engine_if #(
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned IDLE_W  = 8,
    parameter int unsigned RETRY_W = 4
);
    logic [DIV_W-1:0]   clkdiv;
    logic               swdi;
    logic               swdo;
    logic               swwr;
    logic               swclk;
    logic [1:0]         turnaround;
    logic               dataphase;
    logic [IDLE_W-1:0]  idle_cycles;
    logic [RETRY_W-1:0] retries;
    logic               linereset;
    logic [1:0]         addr32;
    logic               rnw;
    logic               apndp;
    logic [31:0]        dwrite;
    logic               go;
    logic               busy;
    logic               done;
    logic [2:0]         ack;
    logic [31:0]        dread;
    logic               perr;
    logic [RETRY_W-1:0] retry_cnt;

    modport master (
        output clkdiv, swdi, turnaround, dataphase, idle_cycles, retries, linereset,
               addr32, rnw, apndp, dwrite, go,
        input  swdo, swwr, swclk, busy, done, ack, dread, perr, retry_cnt
    );

    modport slave (
        input  clkdiv, swdi, turnaround, dataphase, idle_cycles, retries, linereset,
               addr32, rnw, apndp, dwrite, go,
        output swdo, swwr, swclk, busy, done, ack, dread, perr, retry_cnt
    );
endinterface

// File: rtl/swd_engine.sv
// SWD wire-protocol engine: header, turnaround, ack, data phases with WAIT retry and line reset.
// Each bit starts at a falling SWCLK tick (or at accept) and is sampled at the next rising tick.
module swd_engine #(
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned IDLE_W  = 8,
    parameter int unsigned RETRY_W = 4
) (
    input logic         clk,
    input logic         rst_n,
    swd_engine_if.slave bus
);
    localparam int unsigned CntW = IDLE_W + 7;

    typedef enum logic [3:0] {
        StIdle, StLrst, StHdr, StTrn1, StAck, StTrn2, StData, StCool, StFin
    } state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    bit_q, bit_d, cool_len_q, cool_len_d;
    logic               cool_retry_q, cool_retry_d, cool_idle_q, cool_idle_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               swclk_q, swclk_d;
    logic [2:0]         ack_q, ack_d;
    logic [31:0]        dread_q, dread_d;
    logic               perr_q, perr_d;
    logic [32:0]        rsh_q, rsh_d;
    logic [RETRY_W-1:0] rcnt_q, rcnt_d;

    logic [DIV_W-1:0]   clkdiv_q;
    logic [1:0]         trn_q;
    logic               dataphase_q;
    logic [IDLE_W-1:0]  idle_q;
    logic [RETRY_W-1:0] retries_q;
    logic [1:0]         addr_q;
    logic               rnw_q, apndp_q;
    logic [31:0]        dwrite_q;

    logic               active, accept, tick, rise, fall, swdo, swwr;
    logic [CntW-1:0]    trn_len, last_bit;
    logic [7:0]         hdr;

    assign active  = (state_q != StIdle) && (state_q != StFin);
    assign accept  = bus.go && !active;
    assign tick    = active && (div_q == clkdiv_q);
    assign rise    = tick && !swclk_q;
    assign fall    = tick && swclk_q;
    assign trn_len = CntW'(trn_q) + CntW'(1);
    assign hdr     = {1'b1, 1'b0, ^{addr_q, rnw_q, apndp_q}, addr_q, rnw_q, apndp_q, 1'b1};

    always_comb begin
        last_bit = '0;
        case (state_q)
            StLrst:         last_bit = CntW'(57);
            StHdr:          last_bit = CntW'(7);
            StTrn1, StTrn2: last_bit = trn_len - CntW'(1);
            StAck:          last_bit = CntW'(2);
            StData:         last_bit = rnw_q ? CntW'(32) : CntW'(32) + CntW'(idle_q);
            StCool:         last_bit = cool_len_q - CntW'(1);
            default:        last_bit = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        bit_d        = bit_q;
        cool_len_d   = cool_len_q;
        cool_retry_d = cool_retry_q;
        cool_idle_d  = cool_idle_q;
        div_d        = div_q;
        swclk_d      = swclk_q;
        ack_d        = ack_q;
        dread_d      = dread_q;
        perr_d       = perr_q;
        rsh_d        = rsh_q;
        rcnt_d       = rcnt_q;

        if (active) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
            if (tick) swclk_d = !swclk_q;
        end
        // Serial captures fill LSB-first: after the last shift the first bit sits at index 0.
        if (rise && state_q == StAck) ack_d = {bus.swdi, ack_q[2:1]};
        if (rise && state_q == StData && rnw_q) rsh_d = {bus.swdi, rsh_q[32:1]};

        if (fall) begin
            if (bit_q != last_bit) begin
                bit_d = bit_q + CntW'(1);
            end else begin
                bit_d = '0;
                case (state_q)
                    StLrst: state_d = StFin;
                    StHdr:  state_d = StTrn1;
                    StTrn1: state_d = StAck;
                    StAck: begin
                        if (ack_q == 3'b001) begin
                            state_d = rnw_q ? StData : StTrn2;
                        end else begin
                            state_d      = StCool;
                            cool_len_d   = trn_len + CntW'(dataphase_q ? 33 : 0);
                            cool_idle_d  = 1'b0;
                            cool_retry_d = (ack_q == 3'b010) && (rcnt_q < retries_q);
                        end
                    end
                    StTrn2: state_d = StData;
                    StData: begin
                        if (rnw_q) begin
                            dread_d      = rsh_q[31:0];
                            perr_d       = ^rsh_q;
                            state_d      = StCool;
                            cool_len_d   = trn_len + CntW'(idle_q);
                            cool_idle_d  = 1'b1;
                            cool_retry_d = 1'b0;
                        end else begin
                            state_d = StFin;
                        end
                    end
                    StCool: begin
                        if (cool_retry_q) begin
                            state_d = StHdr;
                            if (rcnt_q != '1) rcnt_d = rcnt_q + RETRY_W'(1);
                        end else begin
                            state_d = StFin;
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end

        if (state_q == StFin) state_d = StIdle;
        if (accept) begin
            state_d = bus.linereset ? StLrst : StHdr;
            bit_d   = '0;
            div_d   = '0;
            swclk_d = 1'b0;
            rcnt_d  = '0;
        end
    end

    always_comb begin
        swdo = 1'b0;
        swwr = 1'b0;
        case (state_q)
            StLrst: begin
                swwr = 1'b1;
                swdo = bit_q < CntW'(56);
            end
            StHdr: begin
                swwr = 1'b1;
                swdo = hdr[bit_q[2:0]];
            end
            StData: begin
                if (!rnw_q) begin
                    swwr = 1'b1;
                    if (bit_q < CntW'(32)) swdo = dwrite_q[bit_q[4:0]];
                    else if (bit_q == CntW'(32)) swdo = ^dwrite_q;
                end
            end
            // Read trailer: turnaround released, then host-driven idle zeros.
            StCool:  swwr = cool_idle_q && (bit_q >= trn_len);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            bit_q        <= '0;
            cool_len_q   <= '0;
            cool_retry_q <= 1'b0;
            cool_idle_q  <= 1'b0;
            div_q        <= '0;
            swclk_q      <= 1'b0;
            ack_q        <= '0;
            dread_q      <= '0;
            perr_q       <= 1'b0;
            rsh_q        <= '0;
            rcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            bit_q        <= bit_d;
            cool_len_q   <= cool_len_d;
            cool_retry_q <= cool_retry_d;
            cool_idle_q  <= cool_idle_d;
            div_q        <= div_d;
            swclk_q      <= swclk_d;
            ack_q        <= ack_d;
            dread_q      <= dread_d;
            perr_q       <= perr_d;
            rsh_q        <= rsh_d;
            rcnt_q       <= rcnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clkdiv_q    <= '0;
            trn_q       <= '0;
            dataphase_q <= 1'b0;
            idle_q      <= '0;
            retries_q   <= '0;
            addr_q      <= '0;
            rnw_q       <= 1'b0;
            apndp_q     <= 1'b0;
            dwrite_q    <= '0;
        end else if (accept) begin
            clkdiv_q    <= bus.clkdiv;
            trn_q       <= bus.turnaround;
            dataphase_q <= bus.dataphase;
            idle_q      <= bus.idle_cycles;
            retries_q   <= bus.retries;
            addr_q      <= bus.addr32;
            rnw_q       <= bus.rnw;
            apndp_q     <= bus.apndp;
            dwrite_q    <= bus.dwrite;
        end
    end

    assign bus.swdo      = swdo;
    assign bus.swwr      = swwr;
    assign bus.swclk     = swclk_q;
    assign bus.busy      = active;
    assign bus.done      = (state_q == StFin);
    assign bus.ack       = ack_q;
    assign bus.dread     = dread_q;
    assign bus.perr      = perr_q;
    assign bus.retry_cnt = rcnt_q;
endmodule

// File: tb/tb_swd_engine.sv
// Scoreboard bench for swd_engine: a bit-list protocol model predicts every line bit and result,
// a scripted target answers ACK/data, and a monitor compares at each done pulse.
module tb_swd_engine;
    localparam int unsigned DIV_W   = 8;
    localparam int unsigned IDLE_W  = 8;
    localparam int unsigned RETRY_W = 4;

    typedef struct packed {
        logic [DIV_W-1:0]   clkdiv;
        logic [1:0]         trn;
        logic               dp;
        logic [IDLE_W-1:0]  idle;
        logic [RETRY_W-1:0] retries;
        logic               lr;
        logic [1:0]         addr;
        logic               rnw;
        logic               apndp;
        logic [31:0]        dw;
        logic [31:0]        rdata;
        logic               pflip;
        logic [4:0][2:0]    acks;
    } req_t;

    typedef struct packed {
        logic [2:0]         ack;
        logic [31:0]        dread;
        logic               perr;
        logic [RETRY_W-1:0] rcnt;
        logic [15:0]        nbits;
        logic [511:0]       wr;
        logic [511:0]       dout;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    swd_engine_if #(.DIV_W(DIV_W), .IDLE_W(IDLE_W), .RETRY_W(RETRY_W)) bus ();

    swd_engine #(.DIV_W(DIV_W), .IDLE_W(IDLE_W), .RETRY_W(RETRY_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    exp_t sb_q[$];

    // Model state and per-transaction line image
    logic [2:0]   m_ack = '0;
    logic [31:0]  m_dread = '0;
    logic         m_perr = 1'b0;
    logic [511:0] m_wr, m_do, m_rs;
    int           m_n;

    // Shared with the target/capture process
    logic [511:0] cur_rs = '0;
    int           cur_period = 2;
    int           txn_id = 0;
    logic [511:0] cap_wr = '0, cap_do = '0;
    int           cap_n = 0;
    logic         bad_period = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic put(input logic wr, input logic d, input logic rs);
        m_wr[m_n] = wr;
        m_do[m_n] = d;
        m_rs[m_n] = rs;
        m_n++;
    endtask

    // Expected line and results from the protocol rules.
    task automatic build(input req_t r, output exp_t e);
        int n, rc, att;
        logic [2:0] a;
        logic [7:0] hdr;
        bit fin;
        n = int'(r.trn) + 1;
        rc = 0;
        att = 0;
        fin = 0;
        m_n = 0;
        m_wr = '0;
        m_do = '0;
        m_rs = '0;
        if (r.lr) begin
            for (int i = 0; i < 56; i++) put(1'b1, 1'b1, 1'b0);
            for (int i = 0; i < 2; i++) put(1'b1, 1'b0, 1'b0);
        end else begin
            while (!fin) begin
                a = r.acks[(att < 4) ? att : 4];
                att++;
                hdr = {1'b1, 1'b0, r.apndp ^ r.rnw ^ r.addr[0] ^ r.addr[1],
                       r.addr[1], r.addr[0], r.rnw, r.apndp, 1'b1};
                for (int i = 0; i < 8; i++) put(1'b1, hdr[i], 1'b0);
                for (int i = 0; i < n; i++) put(1'b0, 1'b0, 1'b0);
                for (int i = 0; i < 3; i++) put(1'b0, 1'b0, a[i]);
                m_ack = a;
                if (a == 3'b001) begin
                    if (r.rnw) begin
                        for (int i = 0; i < 32; i++) put(1'b0, 1'b0, r.rdata[i]);
                        put(1'b0, 1'b0, (^r.rdata) ^ r.pflip);
                        for (int i = 0; i < n; i++) put(1'b0, 1'b0, 1'b0);
                        for (int i = 0; i < int'(r.idle); i++) put(1'b1, 1'b0, 1'b0);
                        m_dread = r.rdata;
                        m_perr = r.pflip;
                    end else begin
                        for (int i = 0; i < n; i++) put(1'b0, 1'b0, 1'b0);
                        for (int i = 0; i < 32; i++) put(1'b1, r.dw[i], 1'b0);
                        put(1'b1, ^r.dw, 1'b0);
                        for (int i = 0; i < int'(r.idle); i++) put(1'b1, 1'b0, 1'b0);
                    end
                    fin = 1;
                end else begin
                    for (int i = 0; i < n + (r.dp ? 33 : 0); i++) put(1'b0, 1'b0, 1'b0);
                    if (a == 3'b010 && rc < int'(r.retries)) rc++;
                    else fin = 1;
                end
            end
        end
        e.ack = m_ack;
        e.dread = m_dread;
        e.perr = m_perr;
        e.rcnt = RETRY_W'(rc);
        e.nbits = 16'(m_n);
        e.wr = m_wr;
        e.dout = m_do;
    endtask

    function automatic req_t base_req();
        req_t r;
        r = '0;
        r.acks = {5{3'b001}};
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.clkdiv = DIV_W'($urandom_range(0, 3));
        r.trn = 2'($urandom_range(0, 3));
        r.dp = 1'($urandom_range(0, 1));
        r.idle = IDLE_W'($urandom_range(0, 7));
        r.retries = RETRY_W'($urandom_range(0, 3));
        r.lr = ($urandom_range(0, 9) == 0);
        r.addr = 2'($urandom_range(0, 3));
        r.rnw = 1'($urandom_range(0, 1));
        r.apndp = 1'($urandom_range(0, 1));
        r.dw = $urandom;
        r.rdata = $urandom;
        r.pflip = ($urandom_range(0, 4) == 0);
        for (int i = 0; i < 5; i++) begin
            case ($urandom_range(0, 5))
                0, 1:    r.acks[i] = 3'b001;
                2, 3:    r.acks[i] = 3'b010;
                4:       r.acks[i] = 3'b100;
                default: r.acks[i] = 3'($urandom_range(0, 7));
            endcase
        end
        return r;
    endfunction

    task automatic model_reset();
        m_ack = '0;
        m_dread = '0;
        m_perr = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!bus.done && k < 30000) begin
            @(negedge clk);
            k++;
        end
        if (!bus.done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done, expected done within 30000 clks");
            sb_q.delete();
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            model_reset();
        end
        @(negedge clk);
    endtask

    task automatic run(input req_t r, input bit expect_done);
        exp_t e;
        build(r, e);
        @(negedge clk);
        cur_rs = m_rs;
        cur_period = 2 * (int'(r.clkdiv) + 1);
        txn_id++;
        if (expect_done) sb_q.push_back(e);
        bus.clkdiv = r.clkdiv;
        bus.turnaround = r.trn;
        bus.dataphase = r.dp;
        bus.idle_cycles = r.idle;
        bus.retries = r.retries;
        bus.linereset = r.lr;
        bus.addr32 = r.addr;
        bus.rnw = r.rnw;
        bus.apndp = r.apndp;
        bus.dwrite = r.dw;
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        repeat (2) @(negedge clk);
        // A go while busy carrying different fields must be ignored.
        bus.addr32 = ~r.addr;
        bus.rnw = ~r.rnw;
        bus.linereset = ~r.lr;
        bus.dwrite = ~r.dw;
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        if (expect_done) wait_done();
    endtask

    // Target: records each host bit at a rising SWCLK and presents its reply for the next bit.
    initial begin : target
        int seen_id, clk_cnt, last_rise;
        logic prev;
        seen_id = 0;
        clk_cnt = 0;
        last_rise = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            clk_cnt++;
            if (txn_id != seen_id) begin
                seen_id = txn_id;
                cap_n = 0;
                bad_period = 1'b0;
            end
            if (!rst_n) begin
                prev = 1'b0;
            end else begin
                if (bus.swclk && !prev) begin
                    if (cap_n < 512) begin
                        cap_wr[cap_n] = bus.swwr;
                        cap_do[cap_n] = bus.swdo;
                    end
                    if (cap_n > 0 && (clk_cnt - last_rise) != cur_period) bad_period = 1'b1;
                    last_rise = clk_cnt;
                    cap_n++;
                end
                prev = bus.swclk;
            end
            bus.swdi = (cap_n < 512) ? cur_rs[cap_n] : 1'b0;
        end
    end

    initial begin : monitor
        exp_t e;
        int nbad;
        forever begin
            @(negedge clk);
            if (rst_n && bus.done) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1, expected no done");
                end else begin
                    e = sb_q.pop_front();
                    nbad = 0;
                    for (int i = 0; i < 512; i++) begin
                        if (i < int'(e.nbits)) begin
                            if (cap_wr[i] !== e.wr[i] || (e.wr[i] && cap_do[i] !== e.dout[i]))
                                nbad++;
                        end
                    end
                    chk("ack", 32'(bus.ack), 32'(e.ack));
                    chk("dread", bus.dread, e.dread);
                    chk("perr", 32'(bus.perr), 32'(e.perr));
                    chk("retry_cnt", 32'(bus.retry_cnt), 32'(e.rcnt));
                    chk("bit_count", 32'(cap_n), 32'(e.nbits));
                    chk("line_bit_mismatches", 32'(nbad), 32'd0);
                    chk("swclk_period_bad", 32'(bad_period), 32'd0);
                    chk("busy_at_done", 32'(bus.busy), 32'd0);
                    chk("swclk_at_done", 32'(bus.swclk), 32'd0);
                    chk("swwr_at_done", 32'(bus.swwr), 32'd0);
                end
                @(negedge clk);
                chk("done_width", 32'(bus.done), 32'd0);
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no finish, expected finish before 900000 time units");
        $fatal(1);
    end

    initial begin : stim
        req_t r;
        int k;
        bus.clkdiv = '0;
        bus.turnaround = '0;
        bus.dataphase = 1'b0;
        bus.idle_cycles = '0;
        bus.retries = '0;
        bus.linereset = 1'b0;
        bus.addr32 = '0;
        bus.rnw = 1'b0;
        bus.apndp = 1'b0;
        bus.dwrite = '0;
        bus.go = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_dread", bus.dread, 32'd0);
        chk("rst_swclk_swdo_swwr", 32'({bus.swclk, bus.swdo, bus.swwr}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // Read DP addr 0, good data
        r = base_req();
        r.rnw = 1'b1;
        r.rdata = 32'h2BA01477;
        run(r, 1);
        chk("header_byte", 32'(cap_do[7:0]), 32'hA5);

        // Write AP addr32=1, all ones, two idle bits
        r = base_req();
        r.apndp = 1'b1;
        r.addr = 2'd1;
        r.dw = 32'hFFFFFFFF;
        r.idle = 8'd2;
        run(r, 1);

        // Two WAITs then OK, retries=3
        r = base_req();
        r.rnw = 1'b1;
        r.rdata = 32'h12345678;
        r.retries = 4'd3;
        r.acks = {3'b001, 3'b001, 3'b001, 3'b010, 3'b010};
        run(r, 1);

        // WAIT forever, retries=1, data phase
        r = base_req();
        r.retries = 4'd1;
        r.dp = 1'b1;
        r.trn = 2'd2;
        r.acks = {5{3'b010}};
        run(r, 1);

        // WAIT with retry disabled, then FAULT
        r = base_req();
        r.acks = {5{3'b010}};
        run(r, 1);
        r.acks = {5{3'b100}};
        r.retries = 4'd2;
        run(r, 1);

        // Read with bad parity, then line reset keeps ack/dread/perr
        r = base_req();
        r.rnw = 1'b1;
        r.rdata = 32'hCAFEF00D;
        r.pflip = 1'b1;
        r.trn = 2'd3;
        r.idle = 8'd3;
        run(r, 1);
        r = base_req();
        r.lr = 1'b1;
        run(r, 1);

        // clkdiv=3 read completes, then reset in the middle of DATA
        r = base_req();
        r.rnw = 1'b1;
        r.clkdiv = 8'd3;
        r.rdata = 32'h0F0F5AA5;
        run(r, 1);
        run(r, 0);
        k = 0;
        while (cap_n < 22 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("reached_data_phase", 32'(cap_n >= 22), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy_done", 32'({bus.busy, bus.done}), 32'd0);
        chk("midrst_swclk_swdo_swwr", 32'({bus.swclk, bus.swdo, bus.swwr}), 32'd0);
        chk("midrst_ack_perr_rcnt", 32'({bus.ack, bus.perr, bus.retry_cnt}), 32'd0);
        chk("midrst_dread", bus.dread, 32'd0);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        for (int i = 0; i < 25; i++) run(rand_req(), 1);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
